// File: rtl/nasti_stream_pkg.sv
// Shared NASTI encodings and the fetcher control-state type.
package nasti_stream_pkg;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespExokay = 2'b01,
    RespSlverr = 2'b10,
    RespDecerr = 2'b11
  } nasti_resp_e;

  localparam logic [1:0] BurstIncr = 2'b01;

  typedef enum logic [2:0] {
    StIdle,
    StNull,
    StAddr,
    StRead,
    StDrain
  } fetch_state_e;

endpackage

// File: rtl/stream_beat_fifo.sv
// Synchronous beat FIFO; pointers carry one extra wrap bit to tell full from empty.
module stream_beat_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 65
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned BUF_SHIFT = $clog2(DEPTH);

  logic [BUF_SHIFT:0] wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic               do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {BUF_SHIFT{1'b0}}});
  assign count    = wr_ptr_q - rd_ptr_q;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q[BUF_SHIFT-1:0]];

  // Pointer advance; push and pop may coincide.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push)   wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage array, contents need no reset.
  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q[BUF_SHIFT-1:0]] <= push_data;
  end

  assert property (@(posedge aclk) disable iff (areset) !(push && full))
    else $error("stream_beat_fifo: push while full");

endmodule

// File: rtl/nasti_stream_fetcher.sv
// Reads a contiguous beat-aligned region over NASTI AR/R and replays it as a stream
// with t_last on the final beat. Each AR burst is issued only once the beat buffer
// can absorb all of it, so the R channel is never back-pressured.
module nasti_stream_fetcher
  import nasti_stream_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = 64,
  parameter int unsigned DATA_WIDTH       = 64,
  parameter int unsigned MAX_BURST_LENGTH = 8,
  parameter int unsigned LEN_WIDTH        = 32,
  parameter int unsigned ID_WIDTH         = 4
) (
  input  logic                    aclk,
  input  logic                    areset,
  // NASTI master, read side
  output logic                    src_ar_valid,
  input  logic                    src_ar_ready,
  output logic [ID_WIDTH-1:0]     src_ar_id,
  output logic [ADDR_WIDTH-1:0]   src_ar_addr,
  output logic [7:0]              src_ar_len,
  output logic [2:0]              src_ar_size,
  output logic [1:0]              src_ar_burst,
  output logic                    src_ar_lock,
  output logic [3:0]              src_ar_cache,
  output logic [2:0]              src_ar_prot,
  output logic [3:0]              src_ar_qos,
  output logic [3:0]              src_ar_region,
  input  logic                    src_r_valid,
  output logic                    src_r_ready,
  input  logic [DATA_WIDTH-1:0]   src_r_data,
  input  logic [1:0]              src_r_resp,
  input  logic                    src_r_last,
  // Write side unused
  output logic                    src_aw_valid,
  output logic                    src_w_valid,
  output logic                    src_b_ready,
  // Stream master
  output logic                    dest_t_valid,
  input  logic                    dest_t_ready,
  output logic [DATA_WIDTH-1:0]   dest_t_data,
  output logic [DATA_WIDTH/8-1:0] dest_t_keep,
  output logic [DATA_WIDTH/8-1:0] dest_t_strb,
  output logic                    dest_t_last,
  // Request interface
  input  logic [ADDR_WIDTH-1:0]   r_src,
  input  logic [LEN_WIDTH-1:0]    r_beats,
  input  logic                    r_valid,
  output logic                    r_ready,
  output logic                    r_error
);

  localparam int unsigned BEAT_SHIFT = $clog2(DATA_WIDTH / 8);
  localparam int unsigned BUF_SHIFT  = $clog2(MAX_BURST_LENGTH);
  localparam int unsigned CNT_W      = BUF_SHIFT + 1;

  fetch_state_e           state_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [LEN_WIDTH-1:0]   remaining_q, total_q, pushed_q;
  logic                   r_ready_q, r_error_q, ar_valid_q;

  logic [CNT_W-1:0]       burst, free_slots, fifo_count;
  logic                   fifo_full, fifo_empty, fifo_push, fifo_pop, push_last;
  logic [DATA_WIDTH:0]    fifo_head;
  logic                   ar_fire, r_fire, null_beat;

  // Next burst size: whatever is left, capped at one full buffer.
  always_comb begin
    burst = CNT_W'(MAX_BURST_LENGTH);
    if (remaining_q < LEN_WIDTH'(MAX_BURST_LENGTH)) burst = remaining_q[CNT_W-1:0];
  end

  assign free_slots = CNT_W'(MAX_BURST_LENGTH) - fifo_count;
  assign ar_fire    = ar_valid_q && src_ar_ready;
  assign r_fire     = src_r_valid && src_r_ready;
  assign push_last  = ((pushed_q + LEN_WIDTH'(1)) == total_q);
  assign null_beat  = (state_q == StNull);

  assign fifo_push  = r_fire;
  assign fifo_pop   = dest_t_ready && !fifo_empty;

  // Control FSM with registered handshake outputs.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= StIdle;
      r_ready_q   <= 1'b1;
      r_error_q   <= 1'b0;
      ar_valid_q  <= 1'b0;
      addr_q      <= '0;
      remaining_q <= '0;
      total_q     <= '0;
      pushed_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (r_valid) begin
            addr_q      <= {r_src[ADDR_WIDTH-1:BEAT_SHIFT], {BEAT_SHIFT{1'b0}}};
            remaining_q <= r_beats;
            total_q     <= r_beats;
            pushed_q    <= '0;
            r_error_q   <= 1'b0;
            r_ready_q   <= 1'b0;
            state_q     <= (r_beats == '0) ? StNull : StAddr;
          end
        end
        StNull: begin
          if (dest_t_ready) begin
            r_ready_q <= 1'b1;
            state_q   <= StIdle;
          end
        end
        StAddr: begin
          // No burst is outstanding here, so occupancy alone is the reservation.
          if (!ar_valid_q) begin
            if (free_slots >= burst) ar_valid_q <= 1'b1;
          end else if (ar_fire) begin
            ar_valid_q  <= 1'b0;
            addr_q      <= addr_q + (ADDR_WIDTH'(burst) << BEAT_SHIFT);
            remaining_q <= remaining_q - LEN_WIDTH'(burst);
            state_q     <= StRead;
          end
        end
        StRead: begin
          if (r_fire) begin
            pushed_q <= pushed_q + LEN_WIDTH'(1);
            if (src_r_resp != RespOkay) r_error_q <= 1'b1;
            if (src_r_last) state_q <= (remaining_q != '0) ? StAddr : StDrain;
          end
        end
        StDrain: begin
          if (fifo_empty) begin
            r_ready_q <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  stream_beat_fifo #(
    .DEPTH (MAX_BURST_LENGTH),
    .WIDTH (DATA_WIDTH + 1)
  ) u_beat_fifo (
    .aclk      (aclk),
    .areset    (areset),
    .push      (fifo_push),
    .push_data ({push_last, src_r_data}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign r_ready       = r_ready_q;
  assign r_error       = r_error_q;

  assign src_ar_valid  = ar_valid_q;
  assign src_ar_id     = '0;
  assign src_ar_addr   = addr_q;
  assign src_ar_len    = 8'(burst - 1'b1);
  assign src_ar_size   = 3'(BEAT_SHIFT);
  assign src_ar_burst  = BurstIncr;
  assign src_ar_lock   = 1'b0;
  assign src_ar_cache  = '0;
  assign src_ar_prot   = '0;
  assign src_ar_qos    = '0;
  assign src_ar_region = '0;
  assign src_r_ready   = (state_q == StRead);
  assign src_aw_valid  = 1'b0;
  assign src_w_valid   = 1'b0;
  assign src_b_ready   = 1'b0;

  // A null request emits a single empty beat flagged last.
  assign dest_t_valid  = null_beat || !fifo_empty;
  assign dest_t_data   = null_beat ? '0 : fifo_head[DATA_WIDTH-1:0];
  assign dest_t_last   = null_beat || (!fifo_empty && fifo_head[DATA_WIDTH]);
  assign dest_t_keep   = null_beat ? '0 : '1;
  assign dest_t_strb   = null_beat ? '0 : '1;

  assert property (@(posedge aclk) disable iff (areset)
                   (r_valid && r_ready) |-> (r_src[BEAT_SHIFT-1:0] == '0))
    else $error("nasti_stream_fetcher: misaligned request address");

  assert property (@(posedge aclk) disable iff (areset) !(fifo_push && fifo_full))
    else $error("nasti_stream_fetcher: beat buffer overrun");

endmodule

// File: tb/tb_nasti_stream_fetcher.sv
// Directed bench: zero-wait read slave, stream sink with per-beat checks.
module tb_nasti_stream_fetcher;
  import nasti_stream_pkg::*;

  logic        aclk = 1'b0;
  logic        areset;
  logic        src_ar_valid, src_ar_ready;
  logic [3:0]  src_ar_id;
  logic [63:0] src_ar_addr;
  logic [7:0]  src_ar_len;
  logic [2:0]  src_ar_size;
  logic [1:0]  src_ar_burst;
  logic        src_ar_lock;
  logic [3:0]  src_ar_cache;
  logic [2:0]  src_ar_prot;
  logic [3:0]  src_ar_qos, src_ar_region;
  logic        src_r_valid, src_r_ready;
  logic [63:0] src_r_data;
  logic [1:0]  src_r_resp;
  logic        src_r_last;
  logic        src_aw_valid, src_w_valid, src_b_ready;
  logic        dest_t_valid, dest_t_ready;
  logic [63:0] dest_t_data;
  logic [7:0]  dest_t_keep, dest_t_strb;
  logic        dest_t_last;
  logic [63:0] r_src;
  logic [31:0] r_beats;
  logic        r_valid, r_ready, r_error;

  int          n_cmp = 0;
  int          n_err = 0;
  int          ar_n, rx_count, last_count, rr_stall, exp_beats, exp_rx;
  logic [63:0] ar_addr_log [16];
  logic [7:0]  ar_len_log  [16];
  logic [63:0] exp_base, err_addr;
  bit          expect_null;

  nasti_stream_fetcher u_dut (
    .aclk          (aclk),
    .areset        (areset),
    .src_ar_valid  (src_ar_valid),
    .src_ar_ready  (src_ar_ready),
    .src_ar_id     (src_ar_id),
    .src_ar_addr   (src_ar_addr),
    .src_ar_len    (src_ar_len),
    .src_ar_size   (src_ar_size),
    .src_ar_burst  (src_ar_burst),
    .src_ar_lock   (src_ar_lock),
    .src_ar_cache  (src_ar_cache),
    .src_ar_prot   (src_ar_prot),
    .src_ar_qos    (src_ar_qos),
    .src_ar_region (src_ar_region),
    .src_r_valid   (src_r_valid),
    .src_r_ready   (src_r_ready),
    .src_r_data    (src_r_data),
    .src_r_resp    (src_r_resp),
    .src_r_last    (src_r_last),
    .src_aw_valid  (src_aw_valid),
    .src_w_valid   (src_w_valid),
    .src_b_ready   (src_b_ready),
    .dest_t_valid  (dest_t_valid),
    .dest_t_ready  (dest_t_ready),
    .dest_t_data   (dest_t_data),
    .dest_t_keep   (dest_t_keep),
    .dest_t_strb   (dest_t_strb),
    .dest_t_last   (dest_t_last),
    .r_src         (r_src),
    .r_beats       (r_beats),
    .r_valid       (r_valid),
    .r_ready       (r_ready),
    .r_error       (r_error)
  );

  initial forever #5 aclk = ~aclk;

  function automatic logic [63:0] pat(input logic [63:0] a);
    return {a[31:0] ^ 32'hC0DE_5EED, a[31:0]};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic start_req(input logic [63:0] a, input int n);
    exp_base    = a;
    exp_beats   = n;
    expect_null = (n == 0);
    exp_rx      = (n == 0) ? 1 : n;
    rx_count    = 0;
    last_count  = 0;
    ar_n        = 0;
    r_src       = a;
    r_beats     = 32'(n);
    r_valid     = 1'b1;
    tick();
    r_valid     = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!(r_ready && rx_count == exp_rx) && k < 500) begin
      tick();
      k++;
    end
    check_eq(tag, 64'(k < 500), 1);
  endtask

  // Zero-wait read slave: one burst at a time, data is a function of beat address.
  initial begin
    int          left;
    logic [63:0] baddr, a_addr;
    logic [7:0]  a_len;
    bit          arf, rf, rs;
    left         = 0;
    baddr        = '0;
    src_ar_ready = 1'b1;
    src_r_valid  = 1'b0;
    src_r_data   = '0;
    src_r_last   = 1'b0;
    src_r_resp   = RespOkay;
    forever begin
      @(negedge aclk);
      arf    = src_ar_valid && src_ar_ready;
      rf     = src_r_valid && src_r_ready;
      rs     = areset;
      a_addr = src_ar_addr;
      a_len  = src_ar_len;
      if (arf && !rs && ar_n < 16) begin
        ar_addr_log[ar_n] = a_addr;
        ar_len_log[ar_n]  = a_len;
        ar_n++;
      end
      @(posedge aclk);
      #1;
      if (rs) left = 0;
      else if (arf) begin
        baddr = a_addr;
        left  = int'(a_len) + 1;
      end else if (rf) begin
        baddr = baddr + 64'd8;
        left--;
      end
      src_ar_ready = (left == 0);
      src_r_valid  = (left != 0);
      src_r_data   = pat(baddr);
      src_r_last   = (left == 1);
      src_r_resp   = (left != 0 && baddr == err_addr) ? RespSlverr : RespOkay;
    end
  end

  // Stream sink and R back-pressure monitor.
  initial forever begin
    @(negedge aclk);
    if (src_r_valid && !src_r_ready && !areset) rr_stall++;
    if (dest_t_valid && dest_t_ready && !areset) begin
      if (expect_null) begin
        check_eq("null_keep", dest_t_keep, 0);
        check_eq("null_last", dest_t_last, 1);
      end else begin
        check_eq("beat_data", dest_t_data, pat(exp_base + 64'(rx_count) * 64'd8));
        check_eq("beat_last", dest_t_last, 64'(rx_count == exp_beats - 1));
        check_eq("beat_keep", dest_t_keep, 8'hFF);
      end
      if (dest_t_last) last_count++;
      rx_count++;
    end
  end

  initial begin
    int k;
    areset       = 1'b1;
    r_valid      = 1'b0;
    r_src        = '0;
    r_beats      = '0;
    dest_t_ready = 1'b1;
    err_addr     = '1;
    rr_stall     = 0;
    rx_count     = 0;
    ar_n         = 0;
    tick();
    tick();
    check_eq("rst_r_ready", r_ready, 1);
    check_eq("rst_r_error", r_error, 0);
    check_eq("rst_ar_valid", src_ar_valid, 0);
    check_eq("rst_src_r_ready", src_r_ready, 0);
    check_eq("rst_t_valid", dest_t_valid, 0);
    check_eq("rst_t_last", dest_t_last, 0);
    areset = 1'b0;
    tick();

    // 1: single full burst
    start_req(64'h1000, 8);
    wait_done("t1_done");
    check_eq("t1_ar_n", ar_n, 1);
    check_eq("t1_ar_addr", ar_addr_log[0], 64'h1000);
    check_eq("t1_ar_len", ar_len_log[0], 7);
    check_eq("t1_ar_size", src_ar_size, 3);
    check_eq("t1_ar_burst", src_ar_burst, 1);
    check_eq("t1_lasts", last_count, 1);
    check_eq("t1_r_error", r_error, 0);

    // 2: three bursts, short tail
    start_req(64'h1000, 19);
    wait_done("t2_done");
    check_eq("t2_ar_n", ar_n, 3);
    check_eq("t2_ar0", ar_addr_log[0], 64'h1000);
    check_eq("t2_ar1", ar_addr_log[1], 64'h1040);
    check_eq("t2_ar2", ar_addr_log[2], 64'h1080);
    check_eq("t2_len0", ar_len_log[0], 7);
    check_eq("t2_len1", ar_len_log[1], 7);
    check_eq("t2_len2", ar_len_log[2], 2);
    check_eq("t2_lasts", last_count, 1);

    // 3: stalled stream withholds the second AR until the buffer drains
    dest_t_ready = 1'b0;
    rr_stall     = 0;
    start_req(64'h2000, 16);
    repeat (20) tick();
    check_eq("t3_ar_held", ar_n, 1);
    check_eq("t3_no_out", rx_count, 0);
    dest_t_ready = 1'b1;
    wait_done("t3_done");
    check_eq("t3_ar_n", ar_n, 2);
    check_eq("t3_ar1", ar_addr_log[1], 64'h2040);
    check_eq("t3_rr_stall", rr_stall, 0);
    check_eq("t3_lasts", last_count, 1);

    // 4: null transfer
    start_req(64'h3000, 0);
    check_eq("t4_busy", r_ready, 0);
    k = 0;
    while (rx_count == 0 && k < 50) begin
      tick();
      k++;
    end
    check_eq("t4_beat_seen", rx_count, 1);
    check_eq("t4_r_ready", r_ready, 1);
    tick();
    tick();
    check_eq("t4_one_beat", rx_count, 1);
    check_eq("t4_t_valid", dest_t_valid, 0);
    check_eq("t4_ar_n", ar_n, 0);
    expect_null = 1'b0;

    // 5: SLVERR on the third beat, then cleared by the next accept
    err_addr = 64'h4010;
    start_req(64'h4000, 8);
    wait_done("t5_done");
    check_eq("t5_r_error", r_error, 1);
    err_addr = '1;
    start_req(64'h4100, 1);
    check_eq("t5_err_clr", r_error, 0);
    wait_done("t5b_done");
    check_eq("t5b_r_error", r_error, 0);

    // 6: reset in the middle of a read
    start_req(64'h5000, 16);
    k = 0;
    while (rx_count < 3 && k < 100) begin
      tick();
      k++;
    end
    check_eq("t6_midread", 64'(src_r_ready || !r_ready), 1);
    areset = 1'b1;
    tick();
    check_eq("t6_r_ready", r_ready, 1);
    check_eq("t6_r_error", r_error, 0);
    check_eq("t6_ar_valid", src_ar_valid, 0);
    check_eq("t6_src_r_ready", src_r_ready, 0);
    check_eq("t6_t_valid", dest_t_valid, 0);
    check_eq("t6_t_last", dest_t_last, 0);
    areset = 1'b0;
    tick();
    start_req(64'h6000, 8);
    wait_done("t6_done");
    check_eq("t6_ar_n", ar_n, 1);
    check_eq("t6_ar_addr", ar_addr_log[0], 64'h6000);
    check_eq("t6_lasts", last_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
